// File: rtl/async_fifo_rd_pack.sv
// -----------------------------------------------------------------------------
// async_fifo_rd_pack
//
// Read-side consumer of an async FIFO's first-word-fall-through port, living
// entirely in the rd_clk domain.  Pops DW-bit entries and packs NB of them into
// one DW*NB-bit word.  The word is presented on a valid/ready output with a
// per-lane byte-enable mask.  A programmable idle timeout (cfg_tmo) or an
// explicit flush_req pushes out a partially filled word, so trailing bytes
// never sit in the accumulator indefinitely.
//
// Optional build macro: PACK_BIG_ENDIAN_EN
//   undefined : first popped entry lands in lane 0 (little-endian packing)
//   defined   : first popped entry lands in lane NB-1 (big-endian packing);
//               a partial word then occupies the top lanes and out_be has its
//               top cnt bits set.
//
// Ports
//   rd_clk        in   clock (FIFO read-side clock)
//   rd_reset_n    in   synchronous active-low reset
//   fifo_empty    in   FIFO empty flag (combinational, FWFT)
//   fifo_rd_data  in   FIFO head entry, valid while fifo_empty=0
//   fifo_rd_en    out  pop strobe to the FIFO
//   cfg_tmo       in   idle cycles before a partial flush, 0 = timeout off
//   flush_req     in   single-cycle request to push a partial word
//   out_vld       out  output word valid
//   out_rdy       in   downstream accept
//   out_data      out  packed word
//   out_be        out  lane valid mask (contiguous lanes)
// -----------------------------------------------------------------------------
module async_fifo_rd_pack #(
    parameter int DW    = 8,
    parameter int NB    = 4,
    parameter int TMO_W = 8
) (
    input  logic                rd_clk,
    input  logic                rd_reset_n,
    input  logic                fifo_empty,
    input  logic [DW-1:0]       fifo_rd_data,
    output logic                fifo_rd_en,
    input  logic [TMO_W-1:0]    cfg_tmo,
    input  logic                flush_req,
    output logic                out_vld,
    input  logic                out_rdy,
    output logic [DW*NB-1:0]    out_data,
    output logic [NB-1:0]       out_be
);

    localparam int            CW   = $clog2(NB) + 1;
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    logic [CW-1:0]    cnt;
    logic [DW*NB-1:0] acc;
    logic [DW*NB-1:0] acc_wr;
    logic [TMO_W-1:0] tmo_cnt;
    logic             flush_pend;

    logic             out_free;
    logic             tmo_hit;
    logic             flush_fire;
    logic             pop;
    logic [CW-1:0]    lane;

    // Saturating increment for the idle counter; it parks at all-ones so a
    // long idle period never wraps back under cfg_tmo.
    function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v);
        return (&v) ? v : v + TMO_W'(1);
    endfunction

    // Byte-enable mask for a partial word holding n lanes.
    function automatic logic [NB-1:0] lane_mask(input logic [CW-1:0] n);
        logic [NB-1:0] m;
        m = '0;
        for (int i = 0; i < NB; i++) begin
`ifdef PACK_BIG_ENDIAN_EN
            m[i] = (i >= NB - int'(n));
`else
            m[i] = (i < int'(n));
`endif
        end
        return m;
    endfunction

    // ---- control decode (combinational, current state) ----
    assign out_free   = !out_vld || out_rdy;
    assign tmo_hit    = (cfg_tmo != '0) && (tmo_cnt >= cfg_tmo);
    assign flush_fire = (cnt != '0) && (flush_pend || tmo_hit) && out_free;

    // The last lane may only be popped when the output register can take the
    // completed word; a firing flush owns this cycle.
    assign pop        = rd_reset_n && !fifo_empty && !flush_fire &&
                        ((cnt != LAST) || out_free);
    assign fifo_rd_en = pop;

`ifdef PACK_BIG_ENDIAN_EN
    assign lane = LAST - cnt;
`else
    assign lane = cnt;
`endif

    // Accumulator with the head entry dropped into the current lane.
    always_comb begin
        acc_wr = acc;
        for (int i = 0; i < NB; i++) begin
            if (lane == CW'(i)) begin
                acc_wr[i*DW +: DW] = fifo_rd_data;
            end
        end
    end

    // ---- registered state and output word ----
    always_ff @(posedge rd_clk) begin
        if (!rd_reset_n) begin
            out_vld    <= 1'b0;
            out_data   <= '0;
            out_be     <= '0;
            cnt        <= '0;
            acc        <= '0;
            tmo_cnt    <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (out_vld && out_rdy) begin
                out_vld <= 1'b0;
            end

            if (flush_fire) begin
                // acc lanes beyond cnt are still zero from the last clear.
                out_data <= acc;
                out_be   <= lane_mask(cnt);
                out_vld  <= 1'b1;
                cnt      <= '0;
                acc      <= '0;
            end else if (pop) begin
                if (cnt == LAST) begin
                    out_data <= acc_wr;
                    out_be   <= '1;
                    out_vld  <= 1'b1;
                    cnt      <= '0;
                    acc      <= '0;
                end else begin
                    acc <= acc_wr;
                    cnt <= cnt + CW'(1);
                end
            end

            if (pop || flush_fire || (cnt == '0)) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= sat_inc(tmo_cnt);
            end

            // A request against an empty accumulator has nothing to push.
            if (flush_fire || (cnt == '0)) begin
                flush_pend <= 1'b0;
            end else if (flush_req) begin
                flush_pend <= 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    a_no_pop_empty: assert property (@(posedge rd_clk)
        !(fifo_rd_en && fifo_empty));

    a_stall_stable: assert property (@(posedge rd_clk) disable iff (!rd_reset_n)
        (out_vld && !out_rdy) |=> ($stable(out_data) && $stable(out_be)));
`endif

endmodule

// File: tb/tb_async_fifo_rd_pack.sv
module tb_async_fifo_rd_pack;

    logic        rd_clk;
    logic        rd_reset_n;
    logic        fifo_empty;
    logic [7:0]  fifo_rd_data;
    logic        fifo_rd_en;
    logic [7:0]  cfg_tmo;
    logic        flush_req;
    logic        out_vld;
    logic        out_rdy;
    logic [31:0] out_data;
    logic [3:0]  out_be;

    logic [7:0]  q[$];
    int          checks   = 0;
    int          failures = 0;
    int          npop     = 0;
    int          vld_seen;

    async_fifo_rd_pack #(.DW(8), .NB(4), .TMO_W(8)) dut (
        .rd_clk       (rd_clk),
        .rd_reset_n   (rd_reset_n),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .cfg_tmo      (cfg_tmo),
        .flush_req    (flush_req),
        .out_vld      (out_vld),
        .out_rdy      (out_rdy),
        .out_data     (out_data),
        .out_be       (out_be)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Expected packed word for the first n of b0..b3.
    function automatic logic [31:0] pack(input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2, input logic [7:0] b3,
                                         input int n);
        logic [7:0]  b[4];
        logic [31:0] r;
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        r = '0;
        for (int i = 0; i < n; i++) begin
`ifdef PACK_BIG_ENDIAN_EN
            r[(3-i)*8 +: 8] = b[i];
`else
            r[i*8 +: 8] = b[i];
`endif
        end
        return r;
    endfunction

    function automatic logic [31:0] bemask(input int n);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < n; i++) begin
`ifdef PACK_BIG_ENDIAN_EN
            m[3-i] = 1'b1;
`else
            m[i] = 1'b1;
`endif
        end
        return m;
    endfunction

    task automatic refresh();
        fifo_empty   = (q.size() == 0);
        fifo_rd_data = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] v);
        q.push_back(v);
        refresh();
    endtask

    // One clock: sample the pop strobe before the edge, retire the FIFO
    // head after it, leave combinational outputs settled on return.
    task automatic tick();
        logic en;
        #1;
        en = fifo_rd_en;
        @(posedge rd_clk);
        #1;
        if (en) begin
            void'(q.pop_front());
            npop++;
        end
        refresh();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rd_reset_n = 1'b0;
        cfg_tmo    = 8'd0;
        flush_req  = 1'b0;
        out_rdy    = 1'b1;
        refresh();

        // Reset with data waiting in the FIFO
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        ticks(3);
        check_eq("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check_eq("rst_vld", {31'd0, out_vld}, 32'd0);
        check_eq("rst_data", out_data, 32'd0);
        check_eq("rst_be", {28'd0, out_be}, 32'd0);
        check_eq("rst_nopop", npop, 32'd0);

        rd_reset_n = 1'b1;
        #1;
        check_eq("rel_rd_en", {31'd0, fifo_rd_en}, 32'd1);

        // Full word
        ticks(4);
        check_eq("full_pops", npop, 32'd4);
        check_eq("full_vld", {31'd0, out_vld}, 32'd1);
        check_eq("full_data", out_data, pack(8'h11, 8'h22, 8'h33, 8'h44, 4));
        check_eq("full_be", {28'd0, out_be}, 32'hF);
        tick();
        check_eq("full_vld_drop", {31'd0, out_vld}, 32'd0);

        // Back-pressure: two words, output stalled
        out_rdy = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        ticks(5);
        check_eq("bp_data_a", out_data, pack(8'h01, 8'h02, 8'h03, 8'h04, 4));
        ticks(5);
        check_eq("bp_vld", {31'd0, out_vld}, 32'd1);
        check_eq("bp_data_b", out_data, pack(8'h01, 8'h02, 8'h03, 8'h04, 4));
        check_eq("bp_be", {28'd0, out_be}, 32'hF);
        check_eq("bp_left", q.size(), 32'd1);
        check_eq("bp_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        out_rdy = 1'b1;
        tick();
        check_eq("bp2_vld", {31'd0, out_vld}, 32'd1);
        check_eq("bp2_data", out_data, pack(8'h05, 8'h06, 8'h07, 8'h08, 4));
        check_eq("bp2_empty", q.size(), 32'd0);
        tick();
        check_eq("bp2_vld_drop", {31'd0, out_vld}, 32'd0);

        // Timeout partial flush
        cfg_tmo = 8'd5;
        push(8'hAA); push(8'hBB);
        ticks(7);
        check_eq("tmo_early", {31'd0, out_vld}, 32'd0);
        tick();
        check_eq("tmo_vld", {31'd0, out_vld}, 32'd1);
        check_eq("tmo_data", out_data, pack(8'hAA, 8'hBB, 8'h00, 8'h00, 2));
        check_eq("tmo_be", {28'd0, out_be}, bemask(2));
        tick();
        check_eq("tmo_vld_drop", {31'd0, out_vld}, 32'd0);

        // Timeout disabled: a lone byte stays put
        cfg_tmo = 8'd0;
        push(8'hCC);
        vld_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_vld) vld_seen++;
        end
        check_eq("tmo_off", vld_seen, 32'd0);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        tick();
        check_eq("fl1_vld", {31'd0, out_vld}, 32'd1);
        check_eq("fl1_data", out_data, pack(8'hCC, 8'h00, 8'h00, 8'h00, 1));
        check_eq("fl1_be", {28'd0, out_be}, bemask(1));
        tick();

        // Flush requested while the output is stalled
        out_rdy = 1'b0;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        push(8'h01); push(8'h02); push(8'h03);
        ticks(8);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        ticks(3);
        check_eq("flst_hold", out_data, pack(8'h11, 8'h22, 8'h33, 8'h44, 4));
        check_eq("flst_be_hold", {28'd0, out_be}, 32'hF);
        out_rdy = 1'b1;
        tick();
        check_eq("flst_vld", {31'd0, out_vld}, 32'd1);
        check_eq("flst_data", out_data, pack(8'h01, 8'h02, 8'h03, 8'h00, 3));
        check_eq("flst_be", {28'd0, out_be}, bemask(3));
        tick();
        check_eq("flst_vld_drop", {31'd0, out_vld}, 32'd0);

        // Flush with nothing accumulated
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        vld_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_vld) vld_seen++;
        end
        check_eq("fl_empty", vld_seen, 32'd0);

        // Flush request alongside the first pop of a word is ignored
        push(8'h5A); push(8'h6B); push(8'h7C); push(8'h8D);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        ticks(2);
        check_eq("flpop_novld", {31'd0, out_vld}, 32'd0);
        tick();
        check_eq("flpop_data", out_data, pack(8'h5A, 8'h6B, 8'h7C, 8'h8D, 4));
        check_eq("flpop_be", {28'd0, out_be}, 32'hF);
        tick();

        // Reset mid-word discards the partial bytes
        push(8'h55); push(8'h66);
        ticks(2);
        rd_reset_n = 1'b0;
        tick();
        rd_reset_n = 1'b1;
        push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
        ticks(3);
        check_eq("rstmid_novld", {31'd0, out_vld}, 32'd0);
        tick();
        check_eq("rstmid_vld", {31'd0, out_vld}, 32'd1);
        check_eq("rstmid_data", out_data, pack(8'hA1, 8'hA2, 8'hA3, 8'hA4, 4));
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
